// File: rtl/umul_8x8_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : umul_8x8_pkg
//  Description : Shared widths and the HA-array row bundle type for the
//                8x8 approximate multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package umul_8x8_pkg;

    localparam int OP_W   = 8;
    localparam int N_ROWS = 4;
    localparam int T_W    = 9;
    localparam int B_W    = 7;
    localparam int OUT_W  = 16;
    // Widest aligned row (b << 8) plus headroom for the partial-sum carries
    localparam int ROW_W  = 18;

    typedef struct packed {
        logic [T_W-1:0] t;
        logic [B_W-1:0] b;
    } ha_row_t;

endpackage
`default_nettype wire

// File: rtl/umul_row_align.sv
`default_nettype none
// ============================================================================
//  Module      : umul_row_align
//  Description : Weight-aligns one HA-array row pair into an 18-bit value.
//  Revision    : 1.0 - initial release
// ============================================================================
module umul_row_align
    import umul_8x8_pkg::*;
#(
    parameter int ROW_K = 0
) (
    input  ha_row_t          row_in,
    output logic [ROW_W-1:0] row_out
);

    always_comb begin
        row_out = (ROW_W'(row_in.t) << (2 * ROW_K))
                + (ROW_W'(row_in.b) << (2 * ROW_K + 2));
    end

endmodule
`default_nettype wire

// File: rtl/unsigned_mul_8x8_ha_final_add.sv
`default_nettype none
// ============================================================================
//  Module      : unsigned_mul_8x8_ha_final_add
//  Description : Two-stage valid/ready final adder reducing the four HA-array
//                row pairs to the 16-bit product. Optional accumulator is
//                built when UMUL_FINAL_ADD_MAC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module unsigned_mul_8x8_ha_final_add #(
    parameter int OUT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [umul_8x8_pkg::T_W-1:0]  ha_array_0_t,
    input  logic [umul_8x8_pkg::B_W-1:0]  ha_array_0_b,
    input  logic [umul_8x8_pkg::T_W-1:0]  ha_array_1_t,
    input  logic [umul_8x8_pkg::B_W-1:0]  ha_array_1_b,
    input  logic [umul_8x8_pkg::T_W-1:0]  ha_array_2_t,
    input  logic [umul_8x8_pkg::B_W-1:0]  ha_array_2_b,
    input  logic [umul_8x8_pkg::T_W-1:0]  ha_array_3_t,
    input  logic [umul_8x8_pkg::B_W-1:0]  ha_array_3_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              product
`ifdef UMUL_FINAL_ADD_MAC_EN
    ,
    input  logic                          acc_clr,
    output logic [ACC_W-1:0]              acc
`endif
);

    localparam int c_ROW_W  = umul_8x8_pkg::ROW_W;
    localparam int c_N_ROWS = umul_8x8_pkg::N_ROWS;

    if (OUT_W != umul_8x8_pkg::OUT_W) begin : g_bad_out_w
        $error("OUT_W must match umul_8x8_pkg::OUT_W");
    end
    if (ACC_W < OUT_W) begin : g_bad_acc_w
        $error("ACC_W must be at least OUT_W");
    end

    umul_8x8_pkg::ha_row_t  w_ha_rows [c_N_ROWS];
    logic [c_ROW_W-1:0]     w_rows    [c_N_ROWS];

    assign w_ha_rows[0] = {ha_array_0_t, ha_array_0_b};
    assign w_ha_rows[1] = {ha_array_1_t, ha_array_1_b};
    assign w_ha_rows[2] = {ha_array_2_t, ha_array_2_b};
    assign w_ha_rows[3] = {ha_array_3_t, ha_array_3_b};

    for (genvar k = 0; k < c_N_ROWS; k++) begin : g_rows
        umul_row_align #(
            .ROW_K   (k)
        ) u_align (
            .row_in  (w_ha_rows[k]),
            .row_out (w_rows[k])
        );
    end

    logic               r_s1_valid;
    logic [c_ROW_W-1:0] r_p01;
    logic [c_ROW_W-1:0] r_p23;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_product;

    logic               w_s2_ready;
    logic               w_s1_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_ROW_W-1:0] w_sum;

    // Each stage looks only one stage downstream, so out_ready reaches
    // in_ready through exactly two gates.
    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s1_ready = !r_s1_valid  || w_s2_ready;
    assign w_in_xfer  = in_valid && w_s1_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_sum      = r_p01 + r_p23;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_p01      <= '0;
            r_p23      <= '0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_p01      <= w_rows[0] + w_rows[1];
            r_p23      <= w_rows[2] + w_rows[3];
        end else if (w_s2_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Low 16 bits only: legal bundles never exceed 65025, others wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= w_sum[OUT_W-1:0];
            end
        end
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

`ifdef UMUL_FINAL_ADD_MAC_EN
    logic [ACC_W-1:0] r_acc;

    // A clear coinciding with a transfer restarts the sum at this product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_out_xfer) begin
            r_acc <= (acc_clr ? '0 : r_acc) + ACC_W'(r_product);
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end

    assign acc = r_acc;
`else
    logic w_unused_out_xfer;
    assign w_unused_out_xfer = w_out_xfer;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unsigned_mul_8x8_ha_final_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unsigned_mul_8x8_ha_final_add
//  Description : Self-checking bench for the HA-array final-add pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unsigned_mul_8x8_ha_final_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     product;
    logic [3:0][8:0] ha_t;
    logic [3:0][6:0] ha_b;
`ifdef UMUL_FINAL_ADD_MAC_EN
    logic            acc_clr;
    logic [23:0]     acc;
`endif

    unsigned_mul_8x8_ha_final_add #(
        .OUT_W        (16),
        .ACC_W        (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_t (ha_t[0]),
        .ha_array_0_b (ha_b[0]),
        .ha_array_1_t (ha_t[1]),
        .ha_array_1_b (ha_b[1]),
        .ha_array_2_t (ha_t[2]),
        .ha_array_2_b (ha_b[2]),
        .ha_array_3_t (ha_t[3]),
        .ha_array_3_b (ha_b[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
`ifdef UMUL_FINAL_ADD_MAC_EN
        ,
        .acc_clr      (acc_clr),
        .acc          (acc)
`endif
    );

    typedef struct packed {
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        logic [15:0]     exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_exp;
    logic [23:0] acc_model;
    logic        last_in_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: score the handshakes that the coming edge will complete.
    task automatic tick();
        logic        ix;
        logic        ox;
        logic [15:0] op;
        #1;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        op = product;
        last_in_xfer = ix && !rst;
        if (!rst) begin
            if (ox) begin
                if (exp_q.size() == 0) check("spurious_output", 32'd1, 32'd0);
                else                   check("stream_product", 32'(op), 32'(exp_q.pop_front()));
            end
            if (ix) exp_q.push_back(cur_exp);
`ifdef UMUL_FINAL_ADD_MAC_EN
            if (ox)           acc_model = (acc_clr ? 24'd0 : acc_model) + 24'(op);
            else if (acc_clr) acc_model = 24'd0;
`endif
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            acc_model = '0;
        end
    endtask

    task automatic set_bundle(input logic [3:0][8:0] t, input logic [3:0][6:0] b, input logic [15:0] e);
        ha_t    = t;
        ha_b    = b;
        cur_exp = e;
    endtask

    task automatic set_t0(input logic [8:0] v);
        ha_t    = '0;
        ha_b    = '0;
        ha_t[0] = v;
        cur_exp = 16'(v);
    endtask

    // Upstream HA model: row k carries x*y[2k] + 2*x*y[2k+1], split into a
    // t part and a b part worth four times as much.
    task automatic golden(input int x, input int y);
        for (int k = 0; k < 4; k++) begin
            int pp;
            int bb;
            pp = x * ((y >> (2 * k)) & 1) + 2 * x * ((y >> (2 * k + 1)) & 1);
            bb = (pp >> 2) > 127 ? 127 : (pp >> 2);
            ha_t[k] = 9'(pp - 4 * bb);
            ha_b[k] = 7'(bb);
        end
        cur_exp = 16'(x * y);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   sent;
        int   seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ha_t = '0; ha_b = '0; cur_exp = '0; acc_model = '0; last_in_xfer = 1'b0;
`ifdef UMUL_FINAL_ADD_MAC_EN
        acc_clr = 1'b0;
`endif

        for (int i = 0; i < 7; i++) vecs[i] = '0;
        vecs[0].t[0] = 9'h001;                     vecs[0].exp = 16'd1;
        vecs[1].b[3] = 7'h40;                      vecs[1].exp = 16'd16384;
        vecs[2].t[1] = 9'h003; vecs[2].b[2] = 7'h01; vecs[2].exp = 16'd76;
        vecs[3].t[2] = 9'h1FF;                     vecs[3].exp = 16'd8176;
        vecs[4].b[0] = 7'h7F;                      vecs[4].exp = 16'd508;
        vecs[5].t = {4{9'h1FF}}; vecs[5].b = {4{7'h7F}}; vecs[5].exp = 16'd21079;
        vecs[6].t[3] = 9'h1FF; vecs[6].b[3] = 7'h7F; vecs[6].exp = 16'd65216;

        // Reset state
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef UMUL_FINAL_ADD_MAC_EN
        check("reset_acc", 32'(acc), 32'd0);
`endif

        // Directed weight vectors with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_bundle(vecs[i].t, vecs[i].b, vecs[i].exp);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("latency_not_yet", 32'(out_valid), 32'd0);
            tick();
            check("latency_valid", 32'(out_valid), 32'd1);
            check("vector_product", 32'(product), 32'(vecs[i].exp));
            tick();
        end

        // Random legal stream with random handshakes
        for (int c = 0; c < 400; c++) begin
            golden(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        drain();
`ifdef UMUL_FINAL_ADD_MAC_EN
        check("random_acc", 32'(acc), 32'(acc_model));
`endif

        // Backpressure: three bundles offered while downstream stalls
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            set_t0(9'(11 * (sent + 1)));
            in_valid = (sent < 3);
            tick();
            if (last_in_xfer) sent++;
            if (out_valid) check("bp_product_stable", 32'(product), 32'd11);
        end
        check("bp_accepts", 32'(sent), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("bp_release_out_valid", 32'(out_valid), 32'd1);
            set_t0(9'(11 * (sent + 1)));
            in_valid = (sent < 3);
            tick();
            if (last_in_xfer) sent++;
        end
        check("bp_total_accepts", 32'(sent), 32'd3);
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            set_t0(9'(55 + 11 * sent));
            in_valid = (sent < 2);
            tick();
            if (last_in_xfer) sent++;
        end
        check("mid_full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", 32'(seen), 32'd0);

`ifdef UMUL_FINAL_ADD_MAC_EN
        // Accumulator: three transfers of 100, then clear with a transfer of 7
        set_t0(9'd100);
        in_valid = 1'b1;
        tick(); tick(); tick();
        drain();
        check("mac_acc_300", 32'(acc), 32'd300);
        set_t0(9'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 5 && !out_valid; c++) tick();
        check("mac_valid_before_clr", 32'(out_valid), 32'd1);
        acc_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("mac_clr_with_xfer", 32'(acc), 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
